conv_window_gen: RTL and testbench

Streaming 3x3 sliding-window generator for the convolution layers. It accepts a raster-order pixel stream, one pixel per `din_vld` cycle, and buffers the two previous image rows internally. For every accepted pixel whose 3x3 neighbourhood lies fully inside the image ("valid" convolution, no padding), it emits one 9-pixel window. It sits directly downstream of the pixel/feature-map source and directly upstream of the MAC array.

---
 rtl/conv_window_gen_if.sv | 19 +
 rtl/conv_window_gen.sv | 152 +++++++++++++++
 tb/tb_conv_window_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bundle for conv_window_gen.
// CONV_WINDOW_GEN_LAST_EN adds the win_last end-of-frame flag.
interface conv_window_gen_if #(
    parameter int width = 8
) ();
    logic                 din_vld;
    logic [width-1:0]     din;
    logic [9*width-1:0]   win;
    logic                 win_vld;
`ifdef CONV_WINDOW_GEN_LAST_EN
    logic                 win_last;

    modport master (output din_vld, din, input win, win_vld, win_last);
    modport slave  (input din_vld, din, output win, win_vld, win_last);
`else
    modport master (output din_vld, din, input win, win_vld);
    modport slave  (input din_vld, din, output win, win_vld);
`endif
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 valid-convolution window generator with two row buffers.
// Optional CONV_WINDOW_GEN_LAST_EN flags the final window of each frame.
module conv_window_gen #(
    parameter int width = 8,
    parameter int img_w = 28,
    parameter int img_h = 28
) (
    input  logic               clk,
    input  logic               rst,
    conv_window_gen_if.slave   bus
);
    localparam int COL_W = (img_w > 1) ? $clog2(img_w) : 1;
    localparam int ROW_W = (img_h > 1) ? $clog2(img_h) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(img_w - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(img_h - 1);

    typedef enum logic {FILL, STREAM} state_t;

    typedef logic [2:0][width-1:0] wrow_t;
    typedef logic [2:0][2:0][width-1:0] wmat_t;

    state_t             state_reg, state_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   rd_addr;
    logic               accept;
    logic               emit;
    logic               emit_last;
    logic [width-1:0]   lb_rd [2];
    logic [width-1:0]   col_in [3];
    wmat_t              win_sr_reg, win_sr_next;
    wmat_t              win_reg;
    logic               win_vld_reg;

    assign accept = bus.din_vld & ~rst;

    // Counters: raster position of the pixel being accepted this cycle.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (accept) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_W'(1);
            end else begin
                col_next = col_reg + COL_W'(1);
            end
        end
    end

    // Prefetch the column that the next accepted pixel will need, so the
    // buffer read can stay registered without adding output latency.
    assign rd_addr = rst ? '0 : col_next;

    // Line buffer 1 holds the previous row; buffer 0 the row before that.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lb
            logic [width-1:0] mem [img_w];
            logic [width-1:0] rd_reg;
            logic [width-1:0] wr_data;

            assign wr_data = (gi == 1) ? bus.din : lb_rd[1];

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[col_reg] <= wr_data;
                end
                rd_reg <= mem[rd_addr];
            end

            assign lb_rd[gi] = rd_reg;
        end
    endgenerate

    assign col_in[0] = lb_rd[0];
    assign col_in[1] = lb_rd[1];
    assign col_in[2] = bus.din;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign win_sr_next[gi] = wrow_t'({col_in[gi], win_sr_reg[gi][2], win_sr_reg[gi][1]});
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        emit_last  = 1'b0;
        if (accept) begin
            case (state_reg)
                FILL: begin
                    if (row_reg == ROW_W'(1) && col_reg == COL_LAST) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    emit = (col_reg >= COL_W'(2));
                    if (row_reg == ROW_LAST && col_reg == COL_LAST) begin
                        emit_last  = 1'b1;
                        state_next = FILL;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FILL;
            col_reg     <= '0;
            row_reg     <= '0;
            win_sr_reg  <= '0;
            win_reg     <= '0;
            win_vld_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            win_vld_reg <= emit;
            if (accept) begin
                win_sr_reg <= win_sr_next;
            end
            // Output window only moves on emission; consumers see it held otherwise.
            if (emit) begin
                win_reg <= win_sr_next;
            end
        end
    end

    assign bus.win     = win_reg;
    assign bus.win_vld = win_vld_reg;

`ifdef CONV_WINDOW_GEN_LAST_EN
    logic win_last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_last_reg <= 1'b0;
        end else begin
            win_last_reg <= emit_last;
        end
    end

    assign bus.win_last = win_last_reg;
`else
    logic unused_last;
    assign unused_last = emit_last;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x5 image; checks windows,
// their accept positions, strobe/hold behaviour, and reset handling.
module tb_conv_window_gen;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    conv_window_gen_if #(.width(W)) bus ();

    conv_window_gen #(.width(W), .img_w(5), .img_h(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    bit acc_last = 1'b0;
    int hold_err = 0;
    int strobe_err = 0;
    logic [71:0] last_win = '0;
    logic [71:0] cap_win[$];
    int          cap_pos[$];
    logic        cap_last[$];

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_win = '0;
        end else if (bus.win_vld) begin
            cap_win.push_back(bus.win);
            cap_pos.push_back(n_acc);
`ifdef CONV_WINDOW_GEN_LAST_EN
            cap_last.push_back(bus.win_last);
`else
            cap_last.push_back(1'b0);
`endif
            $display("window %0d after pixel %0d: %h", cap_win.size() - 1, n_acc, bus.win);
            last_win = bus.win;
            if (!acc_last) strobe_err++;
        end else if (bus.win !== last_win) begin
            hold_err++;
        end
    end

    function automatic logic [71:0] model_win(input int base, input int k);
        logic [71:0] w;
        int r, c;
        r = 2 + k / 3;
        c = 2 + k % 3;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'(base + (r - 2 + i) * 5 + (c - 2 + j) + 1);
        return w;
    endfunction

    task automatic clear_cap();
        cap_win.delete();
        cap_pos.delete();
        cap_last.delete();
        n_acc = 0;
    endtask

    task automatic send_px(input logic [7:0] v);
        bus.din_vld = 1'b1;
        bus.din     = v;
        @(posedge clk);
        #1;
        n_acc++;
        acc_last = 1'b1;
        bus.din_vld = 1'b0;
    endtask

    task automatic idle_cyc();
        bus.din_vld = 1'b0;
        bus.din     = 8'($urandom);
        @(posedge clk);
        #1;
        acc_last = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int p = 1; p <= 25; p++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle_cyc();
            send_px(8'(base + p));
        end
        idle_cyc();
    endtask

    task automatic check_frame(input string tag, input int base, input int first_idx, input int pos_off);
        for (int k = 0; k < 9; k++) begin
            int idx;
            idx = first_idx + k;
            check_eq($sformatf("%s.present%0d", tag, k), 72'(cap_win.size() > idx), 72'd1);
            if (cap_win.size() > idx) begin
                check_eq($sformatf("%s.win%0d", tag, k), cap_win[idx], model_win(base, k));
                check_eq($sformatf("%s.pos%0d", tag, k), 72'(cap_pos[idx]),
                         72'(pos_off + 5 * (2 + k / 3) + (2 + k % 3) + 1));
`ifdef CONV_WINDOW_GEN_LAST_EN
                check_eq($sformatf("%s.last%0d", tag, k), 72'(cap_last[idx]), 72'(k == 8));
`endif
            end
        end
    endtask

    task automatic check_strobes(input string tag);
        check_eq({tag, ".hold"}, 72'(hold_err), 72'd0);
        check_eq({tag, ".strobe"}, 72'(strobe_err), 72'd0);
        hold_err = 0;
        strobe_err = 0;
    endtask

    initial begin
        logic [71:0] first1, last1, first2;
        first1 = 72'h0d_0c_0b_08_07_06_03_02_01;
        last1  = 72'h19_18_17_14_13_12_0f_0e_0d;
        first2 = 72'h71_70_6f_6c_6b_6a_67_66_65;

        // Reset held with din_vld high and random din.
        rst = 1'b1;
        bus.din_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.din = 8'($urandom);
            @(posedge clk);
            #1;
            check_eq($sformatf("rst.win%0d", i), bus.win, 72'd0);
            check_eq($sformatf("rst.vld%0d", i), 72'(bus.win_vld), 72'd0);
`ifdef CONV_WINDOW_GEN_LAST_EN
            check_eq($sformatf("rst.last%0d", i), 72'(bus.win_last), 72'd0);
`endif
        end
        rst = 1'b0;
        bus.din_vld = 1'b0;
        clear_cap();
        hold_err = 0;
        strobe_err = 0;

        // Single contiguous frame 1..25.
        for (int p = 1; p <= 12; p++) send_px(8'(p));
        check_eq("single.none_before13", 72'(cap_win.size()), 72'd0);
        for (int p = 13; p <= 25; p++) send_px(8'(p));
        idle_cyc();
        check_eq("single.count", 72'(cap_win.size()), 72'd9);
        if (cap_win.size() >= 9) begin
            check_eq("single.first", cap_win[0], first1);
            check_eq("single.last", cap_win[8], last1);
        end
        check_frame("single", 0, 0, 0);
        check_strobes("single");

        // Same frame with random gaps.
        clear_cap();
        send_frame(0, 1'b1);
        repeat (3) idle_cyc();
        check_eq("gaps.count", 72'(cap_win.size()), 72'd9);
        check_frame("gaps", 0, 0, 0);
        check_eq("gaps.held", bus.win, last1);
        check_strobes("gaps");

        // Two back-to-back frames.
        clear_cap();
        for (int p = 1; p <= 25; p++) send_px(8'(p));
        for (int p = 101; p <= 125; p++) send_px(8'(p));
        idle_cyc();
        check_eq("b2b.count", 72'(cap_win.size()), 72'd18);
        check_frame("b2b.f1", 0, 0, 0);
        check_frame("b2b.f2", 100, 9, 25);
        if (cap_win.size() >= 10) begin
            check_eq("b2b.f2first", cap_win[9], first2);
            check_eq("b2b.f2firstpos", 72'(cap_pos[9]), 72'd38);
        end
        check_strobes("b2b");

        // Reset in the middle of a frame.
        for (int p = 1; p <= 7; p++) send_px(8'(200 + p));
        rst = 1'b1;
        bus.din_vld = 1'b1;
        bus.din = 8'hee;
        @(posedge clk);
        #1;
        check_eq("midrst.win", bus.win, 72'd0);
        rst = 1'b0;
        bus.din_vld = 1'b0;
        clear_cap();
        hold_err = 0;
        strobe_err = 0;
        send_frame(0, 1'b0);
        check_eq("midrst.count", 72'(cap_win.size()), 72'd9);
        if (cap_win.size() >= 9) begin
            check_eq("midrst.first", cap_win[0], first1);
            check_eq("midrst.last", cap_win[8], last1);
        end
        check_frame("midrst", 0, 0, 0);
        check_strobes("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
